// File: rtl/uart_port_if.sv
// uart_port_if: CPU-side bus between the memory/IO bus controller and the UART.
//   rdn, wrn    active-low read/write strobes (driven by the master)
//   wdata[7:0]  byte to transmit, valid while wrn is low
//   rdata[7:0]  last received byte
//   rdata_oe    drive enable for rdata onto the shared bus
//   data_ready  a received byte is waiting
//   tbre        transmit holding register empty
//   tsre        transmit shift register empty (line idle)
interface uart_port_if;
    logic       rdn;
    logic       wrn;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rdata_oe;
    logic       data_ready;
    logic       tbre;
    logic       tsre;

    modport master (
        output rdn, wrn, wdata,
        input  rdata, rdata_oe, data_ready, tbre, tsre
    );

    modport slave (
        input  rdn, wrn, wdata,
        output rdata, rdata_oe, data_ready, tbre, tsre
    );
endinterface

// File: rtl/uart_port.sv
// uart_port: 8N1 UART responder replacing the board CPLD UART.
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  uart_port_if.slave: strobes, write data, read data and status
//   txd  serial out, idle high
//   rxd  serial in, asynchronous to clk
//
//   state    | meaning
//   TX_IDLE  | line idle, waiting for a byte in the holding register
//   TX_START | driving the start bit
//   TX_DATA  | shifting out 8 data bits, LSB first
//   TX_STOP  | driving the stop bit; chains straight into the next byte
//   RX_IDLE  | waiting for a falling edge on the synchronised line
//   RX_START | half a bit in, confirming the start bit
//   RX_DATA  | sampling 8 data bits mid-bit, LSB first
//   RX_STOP  | sampling the stop bit; publish or discard the byte
module uart_port #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic         clk,
    input  logic         rst,
    uart_port_if.slave   bus,
    output logic         txd,
    input  logic         rxd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t       tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic [7:0]      hold_q, hold_d;
    logic            tbre_q, tbre_d;
    logic            tsre_q, tsre_d;
    logic            txd_q, txd_d;

    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            data_ready_q, data_ready_d;
    logic            rdata_oe_q, rdata_oe_d;

    logic            wrn_prev_q, wrn_prev_d;
    logic            rdn_prev_q, rdn_prev_d;
    logic            rxd_s1_q, rxd_s1_d;
    logic            rxd_s2_q, rxd_s2_d;
    logic            rxd_prev_q, rxd_prev_d;

    logic            write_edge;
    logic            read_release;

    assign write_edge   = wrn_prev_q & ~bus.wrn;
    assign read_release = ~rdn_prev_q & bus.rdn;

    always_comb begin
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        tx_bit_d     = tx_bit_q;
        tx_shift_d   = tx_shift_q;
        hold_d       = hold_q;
        tbre_d       = tbre_q;
        tsre_d       = tsre_q;
        txd_d        = txd_q;
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rdata_d      = rdata_q;
        data_ready_d = data_ready_q;
        rdata_oe_d   = ~bus.rdn;
        wrn_prev_d   = bus.wrn;
        rdn_prev_d   = bus.rdn;
        rxd_s1_d     = rxd;
        rxd_s2_d     = rxd_s1_q;
        rxd_prev_d   = rxd_s2_q;

        // A write into a full holding register is silently dropped. The TX
        // side only reloads while tbre_q is 0, so the two never collide.
        if (write_edge && tbre_q) begin
            hold_d = bus.wdata;
            tbre_d = 1'b0;
        end

        case (tx_state_q)
            TX_IDLE: begin
                if (!tbre_q) begin
                    tx_shift_d = hold_q;
                    tbre_d     = 1'b1;
                    tsre_d     = 1'b0;
                    txd_d      = 1'b0;
                    tx_cnt_d   = BIT_LAST;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == '0) begin
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = 3'd0;
                    tx_cnt_d   = BIT_LAST;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = BIT_LAST;
                    if (tx_bit_q == 3'd7) begin
                        txd_d      = 1'b1;
                        tx_state_d = TX_STOP;
                    end else begin
                        txd_d      = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == '0) begin
                    // Chain directly into the next start bit when a byte is waiting.
                    if (!tbre_q) begin
                        tx_shift_d = hold_q;
                        tbre_d     = 1'b1;
                        txd_d      = 1'b0;
                        tx_cnt_d   = BIT_LAST;
                        tx_state_d = TX_START;
                    end else begin
                        tsre_d     = 1'b1;
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // Read release clears first so a byte landing on the same edge wins.
        if (read_release) begin
            data_ready_d = 1'b0;
        end

        case (rx_state_q)
            RX_IDLE: begin
                if (rxd_prev_q && !rxd_s2_q) begin
                    rx_cnt_d   = HALF_LAST;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    if (!rxd_s2_q) begin
                        rx_bit_d   = 3'd0;
                        rx_cnt_d   = BIT_LAST;
                        rx_state_d = RX_DATA;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
                    rx_cnt_d   = BIT_LAST;
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == '0) begin
                    if (rxd_s2_q) begin
                        rdata_d      = rx_shift_q;
                        data_ready_d = 1'b1;
                    end
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= 3'd0;
            tx_shift_q   <= 8'h00;
            hold_q       <= 8'h00;
            tbre_q       <= 1'b1;
            tsre_q       <= 1'b1;
            txd_q        <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= 3'd0;
            rx_shift_q   <= 8'h00;
            rdata_q      <= 8'h00;
            data_ready_q <= 1'b0;
            rdata_oe_q   <= 1'b0;
            wrn_prev_q   <= 1'b1;
            rdn_prev_q   <= 1'b1;
            rxd_s1_q     <= 1'b1;
            rxd_s2_q     <= 1'b1;
            rxd_prev_q   <= 1'b1;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            hold_q       <= hold_d;
            tbre_q       <= tbre_d;
            tsre_q       <= tsre_d;
            txd_q        <= txd_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rdata_q      <= rdata_d;
            data_ready_q <= data_ready_d;
            rdata_oe_q   <= rdata_oe_d;
            wrn_prev_q   <= wrn_prev_d;
            rdn_prev_q   <= rdn_prev_d;
            rxd_s1_q     <= rxd_s1_d;
            rxd_s2_q     <= rxd_s2_d;
            rxd_prev_q   <= rxd_prev_d;
        end
    end

    assign txd            = txd_q;
    assign bus.rdata      = rdata_q;
    assign bus.rdata_oe   = rdata_oe_q;
    assign bus.data_ready = data_ready_q;
    assign bus.tbre       = tbre_q;
    assign bus.tsre       = tsre_q;
endmodule

// File: tb/tb_uart_port.sv
module tb_uart_port;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic txd;
    logic rxd = 1'b1;

    uart_port_if bus ();

    uart_port #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .txd (txd),
        .rxd (rxd)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        bit         b2b;
    } tx_exp_t;

    tx_exp_t    tx_q[$];
    logic [7:0] rx_q[$];

    int         last_end = -100;
    logic [7:0] last_rd  = 8'h00;
    logic       last_dr  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // TX monitor: decodes each frame cycle by cycle against the expected byte.
    initial begin : tx_mon
        tx_exp_t    e;
        logic [9:0] pat;
        logic [7:0] got;
        int         start;
        int         bad;
        bit         aborted;
        bit         have;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                start   = cyc;
                bad     = 0;
                aborted = 0;
                got     = 8'h00;
                have    = (tx_q.size() != 0);
                if (have) e = tx_q.pop_front();
                else begin
                    e.data = 8'h00;
                    e.b2b  = 0;
                    n_total++;
                    $display("FAIL tx_unexpected_frame: frame start at cycle %0d, expected none", start);
                end
                pat = {1'b1, e.data, 1'b0};
                for (int k = 0; k < 10 * CPB; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst) begin
                        aborted = 1;
                        break;
                    end
                    if (txd !== pat[k / CPB]) bad++;
                    if ((k % CPB) == CPB / 2 && k / CPB >= 1 && k / CPB <= 8)
                        got[k / CPB - 1] = txd;
                end
                if (!aborted && have) begin
                    chk("tx_frame_data", got, e.data);
                    chk("tx_frame_timing_errors", bad, 0);
                    if (e.b2b) chk("tx_back_to_back_start", start, last_end + 1);
                    last_end = start + 10 * CPB - 1;
                end
            end
        end
    end

    // RX monitor: a new byte shows up as data_ready rising or rdata changing.
    initial begin : rx_mon
        forever begin
            @(negedge clk);
            if (rst) begin
                last_rd = 8'h00;
                last_dr = 1'b0;
            end else begin
                if ((bus.data_ready && !last_dr) || bus.rdata !== last_rd) begin
                    if (rx_q.size() == 0) begin
                        n_total++;
                        $display("FAIL rx_unexpected_byte: got 0x%0h expected none", bus.rdata);
                    end else begin
                        chk("rx_byte", bus.rdata, rx_q.pop_front());
                    end
                end
                last_rd = bus.rdata;
                last_dr = bus.data_ready;
            end
        end
    end

    task automatic write_byte(input logic [7:0] v);
        @(posedge clk);
        #1 bus.wrn = 1'b0;
        bus.wdata = v;
        @(posedge clk);
        #1 bus.wrn = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] v, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, v, 1'b0};
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            #1 rxd = f[k];
            repeat (CPB) @(posedge clk);
        end
        #1 rxd = 1'b1;
    endtask

    task automatic wait_tsre(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.tsre) break;
        end
        chk("tsre_idle_within_bound", bus.tsre, 1'b1);
    endtask

    initial begin : watchdog
        #200000;
        n_total++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "timeout");
    end

    initial begin : stim
        bus.rdn   = 1'b1;
        bus.wrn   = 1'b1;
        bus.wdata = 8'h00;

        // Power-on reset state: {txd,tbre,tsre,data_ready,rdata_oe,rdata}
        repeat (3) @(posedge clk);
        #1 chk("reset_state_initial",
               {txd, bus.tbre, bus.tsre, bus.data_ready, bus.rdata_oe, bus.rdata}, 13'h1C00);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);

        // Single byte 0xA5
        tx_q.push_back('{8'hA5, 1'b0});
        write_byte(8'hA5);
        chk("tbre_low_after_write", bus.tbre, 1'b0);
        @(posedge clk);
        #1 chk("tbre_back_high", bus.tbre, 1'b1);
        chk("tsre_low_on_load", bus.tsre, 1'b0);
        chk("txd_start_bit", txd, 1'b0);
        repeat (39) @(posedge clk);
        #1 chk("tsre_low_last_frame_cycle", bus.tsre, 1'b0);
        @(posedge clk);
        #1 chk("tsre_high_after_40", bus.tsre, 1'b1);
        repeat (5) @(posedge clk);

        // Back-to-back 0x55 then 0x0F, third write dropped
        tx_q.push_back('{8'h55, 1'b0});
        write_byte(8'h55);
        repeat (8) @(posedge clk);
        tx_q.push_back('{8'h0F, 1'b1});
        write_byte(8'h0F);
        chk("tbre_low_second_write", bus.tbre, 1'b0);
        write_byte(8'hFF);
        chk("tbre_low_after_dropped_write", bus.tbre, 1'b0);
        wait_tsre(200);
        repeat (5) @(posedge clk);

        // Receive 0x3C and read it
        rx_q.push_back(8'h3C);
        send_rx(8'h3C, 1'b1);
        repeat (3) @(posedge clk);
        #1 chk("rx_data_ready_3c", bus.data_ready, 1'b1);
        chk("rx_rdata_3c", bus.rdata, 8'h3C);
        @(posedge clk);
        #1 bus.rdn = 1'b0;
        chk("rdata_oe_before_lag", bus.rdata_oe, 1'b0);
        @(posedge clk);
        #1 chk("rdata_oe_after_lag", bus.rdata_oe, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 bus.rdn = 1'b1;
        chk("data_ready_held_during_read", bus.data_ready, 1'b1);
        @(posedge clk);
        #1 chk("data_ready_cleared_on_release", bus.data_ready, 1'b0);
        chk("rdata_oe_dropped", bus.rdata_oe, 1'b0);
        repeat (3) @(posedge clk);

        // One-cycle glitch, then framing error
        #1 rxd = 1'b0;
        @(posedge clk);
        #1 rxd = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("glitch_no_byte", bus.data_ready, 1'b0);
        send_rx(8'h81, 1'b0);
        repeat (4) @(posedge clk);
        #1 chk("framing_error_no_ready", bus.data_ready, 1'b0);
        chk("framing_error_rdata_kept", bus.rdata, 8'h3C);

        // Overwrite unread 0x12 with 0x34, read release on completion edge
        rx_q.push_back(8'h12);
        send_rx(8'h12, 1'b1);
        repeat (2) @(posedge clk);
        #1 chk("rx_ready_0x12", bus.data_ready, 1'b1);
        rx_q.push_back(8'h34);
        fork
            send_rx(8'h34, 1'b1);
            begin
                @(posedge clk);
                repeat (38) @(posedge clk);
                #1 bus.rdn = 1'b0;
                repeat (2) @(posedge clk);
                #1 bus.rdn = 1'b1;
            end
        join
        @(posedge clk);
        #1 chk("set_wins_data_ready", bus.data_ready, 1'b1);
        chk("set_wins_rdata", bus.rdata, 8'h34);
        repeat (3) @(posedge clk);
        chk("tx_queue_drained", tx_q.size(), 0);
        chk("rx_queue_drained", rx_q.size(), 0);

        // Reset in the middle of a frame with a byte held
        tx_q.push_back('{8'hC3, 1'b0});
        write_byte(8'hC3);
        repeat (6) @(posedge clk);
        tx_q.push_back('{8'h3C, 1'b0});
        write_byte(8'h3C);
        repeat (3) @(posedge clk);
        #1 chk("tbre_low_before_reset", bus.tbre, 1'b0);
        chk("data_ready_high_before_reset", bus.data_ready, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("reset_state_midsim",
               {txd, bus.tbre, bus.tsre, bus.data_ready, bus.rdata_oe, bus.rdata}, 13'h1C00);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        tx_q.delete();
        repeat (60) @(posedge clk);
        #1 chk("post_reset_idle",
               {txd, bus.tbre, bus.tsre, bus.data_ready}, 4'hE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
